// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared constants for the multi-port register file.
//   ADDR_WIDTH_DEF / DATA_WIDTH_DEF : default parameter values
//   ZERO_REG                        : hardwired-zero register index
//   A0_REG                          : index of a0, exported continuously
package regfile_pkg;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int ZERO_REG       = 0;
    localparam int A0_REG         = 10;
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if
//   Bus bundle for regfile_mp: read ports, write port, reserve port and
//   scoreboard / a0 observation outputs.
//   master : the client (decode/testbench) driving addresses and writes
//   slave  : the register file
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int NUM_RD_PORTS = 2
) ();
    logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data;
    logic [NUM_RD_PORTS-1:0]            rd_busy;
    logic                               we;
    logic [ADDR_WIDTH-1:0]              wr_addr;
    logic [DATA_WIDTH-1:0]              wr_data;
    logic                               rsv_en;
    logic [ADDR_WIDTH-1:0]              rsv_addr;
    logic [2**ADDR_WIDTH-1:0]           busy_vec;
    logic [ADDR_WIDTH:0]                pending_cnt;
    logic [DATA_WIDTH-1:0]              a0;

    modport master (
        output rd_addr, we, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rd_data, rd_busy, busy_vec, pending_cnt, a0
    );

    modport slave (
        input  rd_addr, we, wr_addr, wr_data, rsv_en, rsv_addr,
        output rd_data, rd_busy, busy_vec, pending_cnt, a0
    );
endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard
//   Pending-write scoreboard: one busy bit per register plus a registered
//   count of set bits, maintained incrementally.
//   clk, rst     : clock, asynchronous active-high reset
//   set_en/addr  : reserve request (register marked pending)
//   clr_en/addr  : write request (pending mark cleared)
//   busy_vec     : full scoreboard, bit 0 always 0
//   pending_cnt  : popcount of busy_vec
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     set_en,
    input  logic [ADDR_WIDTH-1:0]    set_addr,
    input  logic                     clr_en,
    input  logic [ADDR_WIDTH-1:0]    clr_addr,
    output logic [2**ADDR_WIDTH-1:0] busy_vec,
    output logic [ADDR_WIDTH:0]      pending_cnt
);
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

    logic [2**ADDR_WIDTH-1:0] busy_q, busy_d;
    logic [ADDR_WIDTH:0]      cnt_q, cnt_d;
    logic                     set_ok, clr_ok, inc, dec;

    always_comb begin
        set_ok = set_en && (set_addr != ZERO_IDX);
        clr_ok = clr_en && (clr_addr != ZERO_IDX);
        // Count moves only on real bit transitions; a same-address
        // write+reserve leaves the bit set, so it is not a decrement.
        inc    = set_ok && !busy_q[set_addr];
        dec    = clr_ok && busy_q[clr_addr] && !(set_ok && (set_addr == clr_addr));

        busy_d = busy_q;
        if (clr_ok) busy_d[clr_addr] = 1'b0;
        // Applied after the clear so a new producer wins over the write.
        if (set_ok) busy_d[set_addr] = 1'b1;

        cnt_d = cnt_q;
        if (inc && !dec)      cnt_d = cnt_q + (ADDR_WIDTH+1)'(1);
        else if (dec && !inc) cnt_d = cnt_q - (ADDR_WIDTH+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_vec    = busy_q;
    assign pending_cnt = cnt_q;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
//   Multi-read-port register file with pending-write scoreboard.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : regfile_mp_if.slave -- NUM_RD_PORTS combinational read ports
//          (rd_addr/rd_data/rd_busy), synchronous write port
//          (we/wr_addr/wr_data), reserve port (rsv_en/rsv_addr),
//          busy_vec, pending_cnt and a0 (register 10).
//   Optional feature: define REGFILE_BYPASS_EN to forward the in-flight
//   write data onto matching read ports and a0 in the same cycle.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int NUM_RD_PORTS = 2
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    localparam int                    DEPTH    = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);
    localparam logic [ADDR_WIDTH-1:0] A0_IDX   = ADDR_WIDTH'(A0_REG);

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]      busy_w;
    logic                  wr_hit;

    assign wr_hit = bus.we && (bus.wr_addr != ZERO_IDX);

    // Register 0 is never written, so it stays at its reset value of 0.
    always_comb begin
        regs_d = regs_q;
        if (wr_hit) regs_d[bus.wr_addr] = bus.wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) regs_q <= '{default: '0};
        else     regs_q <= regs_d;
    end

    rf_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .set_en      (bus.rsv_en),
        .set_addr    (bus.rsv_addr),
        .clr_en      (bus.we),
        .clr_addr    (bus.wr_addr),
        .busy_vec    (busy_w),
        .pending_cnt (bus.pending_cnt)
    );

    assign bus.busy_vec = busy_w;

`ifdef REGFILE_BYPASS_EN
    logic rsv_same;
    // A forwarded port still reports busy if a new producer reserves the
    // same register in this cycle.
    assign rsv_same = bus.rsv_en && (bus.rsv_addr == bus.wr_addr);
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_rd
            logic [ADDR_WIDTH-1:0] addr;
            assign addr = bus.rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef REGFILE_BYPASS_EN
            logic fwd;
            assign fwd = wr_hit && (bus.wr_addr == addr);
            assign bus.rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = fwd ? bus.wr_data : regs_q[addr];
            assign bus.rd_busy[gi] = fwd ? rsv_same : busy_w[addr];
`else
            assign bus.rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = regs_q[addr];
            assign bus.rd_busy[gi] = busy_w[addr];
`endif
        end
    endgenerate

`ifdef REGFILE_BYPASS_EN
    assign bus.a0 = (wr_hit && (bus.wr_addr == A0_IDX)) ? bus.wr_data : regs_q[A0_IDX];
`else
    assign bus.a0 = regs_q[A0_IDX];
`endif
endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regfile_mp_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD_PORTS(2)) bus ();

    regfile_mp #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD_PORTS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        rsv;
        logic [4:0]  ra;
        logic [4:0]  rd0;
        logic [4:0]  rd1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  ebusy;
        logic [31:0] ebv;
        logic [5:0]  ecnt;
        logic [31:0] ea0;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_rd(input logic [4:0] a0p, input logic [4:0] a1p);
        bus.rd_addr = {a1p, a0p};
    endtask

    task automatic idle_inputs();
        bus.we = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rsv_en = 1'b0; bus.rsv_addr = '0;
    endtask

    initial begin
        // rows: we wa wd rsv ra rd0 rd1 | e0 e1 busy busy_vec cnt a0
        vecs[0]  = '{1, 10, 32'hDEADBEEF, 0, 0, 10, 10, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 32'h0,  6'd0, 32'hDEADBEEF};
        vecs[1]  = '{1, 0,  32'h00001234, 0, 0, 0,  0,  32'h0,        32'h0,        2'b00, 32'h0,  6'd0, 32'hDEADBEEF};
        vecs[2]  = '{0, 0,  32'h0,        1, 3, 3,  0,  32'h0,        32'h0,        2'b01, 32'h8,  6'd1, 32'hDEADBEEF};
        vecs[3]  = '{1, 3,  32'h7,        0, 0, 3,  3,  32'h7,        32'h7,        2'b00, 32'h0,  6'd0, 32'hDEADBEEF};
        vecs[4]  = '{1, 4,  32'h55,       1, 4, 4,  3,  32'h55,       32'h7,        2'b01, 32'h10, 6'd1, 32'hDEADBEEF};
        vecs[5]  = '{0, 0,  32'h0,        1, 0, 0,  4,  32'h0,        32'h55,       2'b10, 32'h10, 6'd1, 32'hDEADBEEF};
        vecs[6]  = '{1, 4,  32'h66,       1, 5, 4,  5,  32'h66,       32'h0,        2'b10, 32'h20, 6'd1, 32'hDEADBEEF};
        vecs[7]  = '{1, 5,  32'h77,       0, 0, 5,  10, 32'h77,       32'hDEADBEEF, 2'b00, 32'h0,  6'd0, 32'hDEADBEEF};
        vecs[8]  = '{1, 6,  32'h88,       0, 0, 6,  6,  32'h88,       32'h88,       2'b00, 32'h0,  6'd0, 32'hDEADBEEF};
        vecs[9]  = '{0, 0,  32'h0,        1, 6, 6,  0,  32'h88,       32'h0,        2'b01, 32'h40, 6'd1, 32'hDEADBEEF};
        vecs[10] = '{0, 0,  32'h0,        1, 6, 6,  6,  32'h88,       32'h88,       2'b11, 32'h40, 6'd1, 32'hDEADBEEF};

        idle_inputs();
        set_rd(5'd5, 5'd0);

        // Reset asserted before any clock edge
        #1 rst = 1'b1;
        #1;
        chk("reset a0", bus.a0, 0);
        chk("reset busy_vec", bus.busy_vec, 0);
        chk("reset pending_cnt", bus.pending_cnt, 0);
        chk("reset rd x5", bus.rd_data[31:0], 0);
        chk("reset rd_busy", bus.rd_busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors; outputs compared after the edge with we/rsv idle
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            bus.we = vecs[i].we; bus.wr_addr = vecs[i].wa; bus.wr_data = vecs[i].wd;
            bus.rsv_en = vecs[i].rsv; bus.rsv_addr = vecs[i].ra;
            set_rd(vecs[i].rd0, vecs[i].rd1);
            @(posedge clk);
            #1 idle_inputs();
            #1;
            chk($sformatf("v%0d rd0", i), bus.rd_data[31:0], vecs[i].e0);
            chk($sformatf("v%0d rd1", i), bus.rd_data[63:32], vecs[i].e1);
            chk($sformatf("v%0d rd_busy", i), bus.rd_busy, vecs[i].ebusy);
            chk($sformatf("v%0d busy_vec", i), bus.busy_vec, vecs[i].ebv);
            chk($sformatf("v%0d pending_cnt", i), bus.pending_cnt, vecs[i].ecnt);
            chk($sformatf("v%0d a0", i), bus.a0, vecs[i].ea0);
            $display("vec %0d: we=%0b wa=%0d rsv=%0b ra=%0d rd=%0d/%0d -> %h %h busy=%b cnt=%0d",
                     i, vecs[i].we, vecs[i].wa, vecs[i].rsv, vecs[i].ra, vecs[i].rd0, vecs[i].rd1,
                     bus.rd_data[31:0], bus.rd_data[63:32], bus.rd_busy, bus.pending_cnt);
        end

        // Same-cycle read of x7 on both ports while writing it
        @(negedge clk);
        set_rd(5'd7, 5'd7);
        bus.we = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'hA5;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass same-cycle p0", bus.rd_data[31:0], 32'hA5);
        chk("bypass same-cycle p1", bus.rd_data[63:32], 32'hA5);
`else
        chk("nobypass same-cycle p0", bus.rd_data[31:0], 32'h0);
        chk("nobypass same-cycle p1", bus.rd_data[63:32], 32'h0);
`endif
        chk("write x7 same-cycle rd_busy", bus.rd_busy, 2'b00);
        @(posedge clk);
        #1 idle_inputs();
        #1;
        chk("write x7 next p0", bus.rd_data[31:0], 32'hA5);
        chk("write x7 next p1", bus.rd_data[63:32], 32'hA5);
        $display("seq bypass x7: %h %h", bus.rd_data[31:0], bus.rd_data[63:32]);

        // a0 behaviour while x10 is being written
        @(negedge clk);
        bus.we = 1'b1; bus.wr_addr = 5'd10; bus.wr_data = 32'h11111111;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("a0 same-cycle", bus.a0, 32'h11111111);
`else
        chk("a0 same-cycle", bus.a0, 32'hDEADBEEF);
`endif
        @(posedge clk);
        #1 idle_inputs();
        #1;
        chk("a0 next", bus.a0, 32'h11111111);
        $display("seq a0 write: a0=%h", bus.a0);

        // Reserve x1..x3, write x2, then reset between edges
        for (int r = 1; r <= 3; r++) begin
            @(negedge clk);
            bus.rsv_en = 1'b1; bus.rsv_addr = 5'(r);
            @(posedge clk);
            #1 idle_inputs();
        end
        @(negedge clk);
        bus.we = 1'b1; bus.wr_addr = 5'd2; bus.wr_data = 32'h9;
        @(posedge clk);
        #1 idle_inputs();
        set_rd(5'd2, 5'd7);
        #1;
        chk("pre-reset x2", bus.rd_data[31:0], 32'h9);
        chk("pre-reset busy_vec", bus.busy_vec, 32'h4A);
        chk("pre-reset pending_cnt", bus.pending_cnt, 6'd3);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst x2", bus.rd_data[31:0], 0);
        chk("midrst x7", bus.rd_data[63:32], 0);
        chk("midrst busy_vec", bus.busy_vec, 0);
        chk("midrst pending_cnt", bus.pending_cnt, 0);
        chk("midrst a0", bus.a0, 0);
        // Write and reserve presented during reset are discarded
        bus.we = 1'b1; bus.wr_addr = 5'd2; bus.wr_data = 32'h5;
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd2;
        @(posedge clk);
        #1;
        chk("rst-edge x2", bus.rd_data[31:0], 0);
        chk("rst-edge busy_vec", bus.busy_vec, 0);
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post-reset x2", bus.rd_data[31:0], 0);
        chk("post-reset pending_cnt", bus.pending_cnt, 0);
        $display("seq midreset: x2=%h busy_vec=%h cnt=%0d", bus.rd_data[31:0], bus.busy_vec, bus.pending_cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
